mc_ctrl_fsm: RTL and testbench

//  Main control sequencer for the multi-cycle 32-bit CPU datapath. Decodes the opcode, steps through

---
 rtl/mc_cpu_pkg.sv | 41 ++++
 rtl/mc_ctrl_fsm.sv | 146 ++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_cpu_pkg.sv
// Shared constants for the multi-cycle CPU control path: opcodes, sequencer
// state codes and the ALU/PC mux select codes.
package mc_cpu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   typedef enum logic [3:0] {
      S_IF   = 4'd0,
      S_ID   = 4'd1,
      S_MA   = 4'd2,
      S_MR   = 4'd3,
      S_LWB  = 4'd4,
      S_MW   = 4'd5,
      S_RX   = 4'd6,
      S_RWB  = 4'd7,
      S_BEQ  = 4'd8,
      S_JMP  = 4'd9,
      S_IX   = 4'd10,
      S_IWB  = 4'd11,
      S_TRAP = 4'd12
   } state_t;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle CPU control sequencer: state register, next-state logic and output decode.
// Define ILLEGAL_TRAP_EN to trap on unknown opcodes instead of treating them as NOPs.
module mc_ctrl_fsm
   import mc_cpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic [3:0] state_o,
   output logic       trap
);

   state_t state_q, state_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IF;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IF:  if (mem_ready) state_d = S_ID;
         S_ID: begin
            case (opcode)
               OP_RTYPE:     state_d = S_RX;
               OP_LW, OP_SW: state_d = S_MA;
               OP_BEQ:       state_d = S_BEQ;
               OP_J:         state_d = S_JMP;
               OP_ADDI:      state_d = S_IX;
`ifdef ILLEGAL_TRAP_EN
               default:      state_d = S_TRAP;
`else
               default:      state_d = S_IF;   // NOP: PC was already advanced in IF
`endif
            endcase
         end
         S_MA:  state_d = (opcode == OP_LW) ? S_MR : S_MW;
         S_MR:  if (mem_ready) state_d = S_LWB;
         S_LWB: state_d = S_IF;
         S_MW:  if (mem_ready) state_d = S_IF;
         S_RX:  state_d = S_RWB;
         S_RWB: state_d = S_IF;
         S_IX:  state_d = S_IWB;
         S_IWB: state_d = S_IF;
         S_BEQ: state_d = S_IF;
         S_JMP: state_d = S_IF;
`ifdef ILLEGAL_TRAP_EN
         S_TRAP: state_d = S_TRAP;
`endif
         default: state_d = S_IF;
      endcase
   end

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_B;
      alu_op        = ALUOP_ADD;
      pc_source     = PCSRC_ALU;
`ifdef ILLEGAL_TRAP_EN
      trap          = 1'b0;
`endif
      case (state_q)
         S_IF: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_ID:  alu_src_b = SRCB_IMM_SH2;
         S_MA: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         S_MR: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         S_LWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MW: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         S_RX: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_FUNCT;
         end
         S_RWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_IX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         S_IWB: reg_write = 1'b1;
         S_BEQ: begin
            alu_src_a     = 1'b1;
            alu_op        = ALUOP_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
         end
         S_JMP: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_JUMP;
         end
`ifdef ILLEGAL_TRAP_EN
         S_TRAP: trap = 1'b1;
`endif
         default: ;
      endcase
   end

`ifndef ILLEGAL_TRAP_EN
   assign trap = 1'b0;
`endif

   assign state_o = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed vector table, hand sequences for stalls/reset/illegal
// opcodes, then random opcodes and mem_ready against an instruction-path model.
module tb_mc_ctrl_fsm;
   import mc_cpu_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] opcode = 6'd0;
   logic       mem_ready = 1'b0;
   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a, trap;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic [3:0] state_o;
   logic [16:0] dvec;

   int checks = 0;
   int errors = 0;

   mc_ctrl_fsm dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .state_o(state_o), .trap(trap)
   );

   always #5 clk = ~clk;

   assign dvec = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                  pc_source, trap};

   // Expected control word for a state, written field by field from the control table.
   function automatic logic [16:0] exp_out(input logic [3:0] st, input logic mr);
      logic pcw, pcwc, iod, mrd, mwr, irw, m2r, rd, rw, sa, trp;
      logic [1:0] sb, aop, psrc;
      {pcw, pcwc, iod, mrd, mwr, irw, m2r, rd, rw, sa, trp} = '0;
      sb = 2'b00; aop = 2'b00; psrc = 2'b00;
      case (st)
         4'd0:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
         4'd1:  sb = 2'b11;
         4'd2:  begin sa = 1; sb = 2'b10; end
         4'd3:  begin mrd = 1; iod = 1; end
         4'd4:  begin rw = 1; m2r = 1; end
         4'd5:  begin mwr = 1; iod = 1; end
         4'd6:  begin sa = 1; aop = 2'b10; end
         4'd7:  begin rw = 1; rd = 1; end
         4'd8:  begin sa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
         4'd9:  begin pcw = 1; psrc = 2'b10; end
         4'd10: begin sa = 1; sb = 2'b10; end
         4'd11: rw = 1;
         4'd12: trp = 1;
         default: ;
      endcase
      return {pcw, pcwc, iod, mrd, mwr, irw, m2r, rd, rw, sa, sb, aop, psrc, trp};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [5:0] op, input logic mr);
      opcode = op;
      mem_ready = mr;
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Instruction-path model: each instruction is IF, ID, then an opcode-dependent tail.
   logic [3:0] path[$];
   int pidx;

   task automatic model_reset();
      path.delete();
      path.push_back(4'd0);
      path.push_back(4'd1);
      pidx = 0;
   endtask

   task automatic model_advance(input logic [5:0] op, input logic mr);
      logic [3:0] st;
      st = path[pidx];
      if (st == 4'd12) return;
      if ((st == 4'd0 || st == 4'd3 || st == 4'd5) && !mr) return;
      if (st == 4'd1) begin
         case (op)
            6'b000000: begin path.push_back(4'd6); path.push_back(4'd7); end
            6'b100011: begin path.push_back(4'd2); path.push_back(4'd3); path.push_back(4'd4); end
            6'b101011: begin path.push_back(4'd2); path.push_back(4'd5); end
            6'b000100: path.push_back(4'd8);
            6'b000010: path.push_back(4'd9);
            6'b001000: begin path.push_back(4'd10); path.push_back(4'd11); end
`ifdef ILLEGAL_TRAP_EN
            default:   path.push_back(4'd12);
`else
            default:   ;
`endif
         endcase
      end
      pidx++;
      if (pidx >= path.size()) model_reset();
   endtask

   typedef struct {
      logic [5:0] op;
      logic       mr;
      logic [3:0] st;
      logic [4:0] key;   // {mem_read, mem_write, ir_write, reg_write, pc_write}
   } vec_t;

   vec_t tbl[27];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      logic [5:0] rop;
      logic       rmr;

      tbl[0]  = '{OP_LW,   1'b0, S_IF,   5'b10000};
      tbl[1]  = '{OP_LW,   1'b1, S_IF,   5'b10101};
      tbl[2]  = '{OP_LW,   1'b0, S_ID,   5'b00000};
      tbl[3]  = '{OP_LW,   1'b1, S_MA,   5'b00000};
      tbl[4]  = '{OP_LW,   1'b0, S_MR,   5'b10000};
      tbl[5]  = '{OP_LW,   1'b1, S_MR,   5'b10000};
      tbl[6]  = '{OP_LW,   1'b0, S_LWB,  5'b00010};
      tbl[7]  = '{OP_SW,   1'b1, S_IF,   5'b10101};
      tbl[8]  = '{OP_SW,   1'b0, S_ID,   5'b00000};
      tbl[9]  = '{OP_SW,   1'b0, S_MA,   5'b00000};
      tbl[10] = '{OP_SW,   1'b0, S_MW,   5'b01000};
      tbl[11] = '{OP_SW,   1'b1, S_MW,   5'b01000};
      tbl[12] = '{OP_RTYPE,1'b1, S_IF,   5'b10101};
      tbl[13] = '{OP_RTYPE,1'b1, S_ID,   5'b00000};
      tbl[14] = '{OP_RTYPE,1'b0, S_RX,   5'b00000};
      tbl[15] = '{OP_RTYPE,1'b1, S_RWB,  5'b00010};
      tbl[16] = '{OP_ADDI, 1'b1, S_IF,   5'b10101};
      tbl[17] = '{OP_ADDI, 1'b0, S_ID,   5'b00000};
      tbl[18] = '{OP_ADDI, 1'b1, S_IX,   5'b00000};
      tbl[19] = '{OP_ADDI, 1'b0, S_IWB,  5'b00010};
      tbl[20] = '{OP_BEQ,  1'b1, S_IF,   5'b10101};
      tbl[21] = '{OP_BEQ,  1'b1, S_ID,   5'b00000};
      tbl[22] = '{OP_BEQ,  1'b1, S_BEQ,  5'b00000};
      tbl[23] = '{OP_J,    1'b1, S_IF,   5'b10101};
      tbl[24] = '{OP_J,    1'b0, S_ID,   5'b00000};
      tbl[25] = '{OP_J,    1'b1, S_JMP,  5'b00001};
      tbl[26] = '{OP_RTYPE,1'b0, S_IF,   5'b10000};

      // Reset state and fetch waiting on memory
      @(posedge clk); #1;
      chk("rst_state", 32'(state_o), 32'(S_IF));
      chk("rst_mem_read", 32'(mem_read), 32'd1);
      chk("rst_ir_write", 32'(ir_write), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive(OP_LW, 1'b0);
         chk("if_wait_state", 32'(state_o), 32'(S_IF));
         chk("if_wait_ir_write", 32'(ir_write), 32'd0);
         tick();
      end

      // Directed vector table
      for (int i = 0; i < 27; i++) begin
         drive(tbl[i].op, tbl[i].mr);
         chk($sformatf("tbl%0d_state", i), 32'(state_o), 32'(tbl[i].st));
         chk($sformatf("tbl%0d_key", i), 32'({mem_read, mem_write, ir_write, reg_write, pc_write}),
             32'(tbl[i].key));
         chk($sformatf("tbl%0d_vec", i), 32'(dvec), 32'(exp_out(tbl[i].st, tbl[i].mr)));
         tick();
      end

      // sw with three stall cycles in MW
      drive(OP_SW, 1'b1); tick();
      drive(OP_SW, 1'b1); tick();
      drive(OP_SW, 1'b1);
      chk("sw_ma_state", 32'(state_o), 32'(S_MA));
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(OP_SW, (i == 3));
         chk($sformatf("sw_stall%0d_state", i), 32'(state_o), 32'(S_MW));
         chk($sformatf("sw_stall%0d_wr_iod", i), 32'({mem_write, i_or_d}), 32'd3);
         tick();
      end
      drive(OP_SW, 1'b0);
      chk("sw_done_state", 32'(state_o), 32'(S_IF));
      chk("sw_done_mem_write", 32'(mem_write), 32'd0);
      tick();

      // j interrupted by asynchronous reset in JMP
      drive(OP_J, 1'b1); tick();
      drive(OP_J, 1'b0); tick();
      drive(OP_J, 1'b0);
      chk("jmp_pc_write", 32'(pc_write), 32'd1);
      rst = 1'b1;
      #1;
      chk("jmp_rst_pc_write", 32'(pc_write), 32'd0);
      chk("jmp_rst_state", 32'(state_o), 32'(S_IF));
      tick();
      rst = 1'b0;

      // Illegal opcode
      drive(6'b111111, 1'b1);
      chk("ill_if_state", 32'(state_o), 32'(S_IF));
      tick();
      drive(6'b111111, 1'b1);
      chk("ill_id_state", 32'(state_o), 32'(S_ID));
      chk("ill_id_vec", 32'(dvec), 32'(exp_out(4'd1, 1'b1)));
      tick();
`ifdef ILLEGAL_TRAP_EN
      for (int i = 0; i < 3; i++) begin
         drive(6'b111111, 1'b1);
         chk($sformatf("trap%0d_state", i), 32'(state_o), 32'(S_TRAP));
         chk($sformatf("trap%0d_vec", i), 32'(dvec), 32'(exp_out(4'd12, 1'b1)));
         tick();
      end
      rst = 1'b1;
      #1;
      chk("trap_rst_trap", 32'(trap), 32'd0);
      tick();
      rst = 1'b0;
`else
      drive(6'b111111, 1'b0);
      chk("ill_nop_state", 32'(state_o), 32'(S_IF));
      chk("ill_nop_writes", 32'({reg_write, mem_write, ir_write, trap}), 32'd0);
      tick();
`endif

      // Random opcodes and memory handshakes against the path model
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      rop = OP_RTYPE;
      for (int n = 0; n < 3000; n++) begin
         if (pidx == 0) begin
            case ($urandom_range(0, 7))
               0: rop = OP_RTYPE;
               1: rop = OP_LW;
               2: rop = OP_SW;
               3: rop = OP_BEQ;
               4: rop = OP_J;
               5: rop = OP_ADDI;
               6: rop = 6'b111111;
               default: rop = 6'($urandom);
            endcase
         end
         rmr = ($urandom_range(0, 9) < 7);
         opcode = rop;
         mem_ready = rmr;
         if ($urandom_range(0, 99) == 0) begin
            rst = 1'b1;
            #1;
            chk("rnd_rst_state", 32'(state_o), 32'(S_IF));
            chk("rnd_rst_vec", 32'(dvec), 32'(exp_out(4'd0, rmr)));
            tick();
            rst = 1'b0;
            model_reset();
            continue;
         end
         @(negedge clk);
         chk("rnd_state", 32'(state_o), 32'(path[pidx]));
         chk("rnd_vec", 32'(dvec), 32'(exp_out(path[pidx], rmr)));
         tick();
         model_advance(rop, rmr);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
